// File: rtl/sine_stream_pkg.sv
// Shared types and elaboration-time helpers for the sine stream source.
package sine_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam real PI = 3.14159265358979323846;

    function automatic int unsigned mid_of(input int unsigned bitsize);
        return 32'd1 << (bitsize - 1);
    endfunction

    function automatic int unsigned amp_of(input int unsigned bitsize, input int unsigned margin);
        return mid_of(bitsize) - margin;
    endfunction

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First-quadrant ROM entry, rounded half away from zero (argument is never negative).
    function automatic int lut_entry(input int unsigned amp, input int unsigned j,
                                     input int unsigned f_sine);
        real x;
        x = real'(amp) * $sin(2.0 * PI * real'(j) / real'(f_sine));
        return $rtoi($floor(x + 0.5));
    endfunction

endpackage

// File: rtl/sine_stream_if.sv
// Sample-stream bundle between the sine source and a filter input.
interface sine_stream_if #(
    parameter int unsigned BITSIZE = 12
);
    logic               EN;
    logic [BITSIZE-1:0] DATA_OUT;
    logic               START_FLAG;
    logic               BUSY;
    logic               DONE;

    modport master (input EN, output DATA_OUT, output START_FLAG, output BUSY, output DONE);
    modport slave  (output EN, input DATA_OUT, input START_FLAG, input BUSY, input DONE);
endinterface

// File: rtl/sine_quarter_lut.sv
// Combinational quarter-wave sine ROM, Q+1 entries, contents fixed at elaboration.
module sine_quarter_lut
    import sine_stream_pkg::*;
#(
    parameter int unsigned BITSIZE    = 12,
    parameter int unsigned F_SINE     = 256,
    parameter int unsigned AMP_MARGIN = 10,
    parameter int unsigned AW         = 7
) (
    input  logic [AW-1:0]      addr_i,
    output logic [BITSIZE-2:0] data_o
);
    localparam int unsigned Q   = F_SINE / 4;
    localparam int unsigned AMP = amp_of(BITSIZE, AMP_MARGIN);

    logic [BITSIZE-2:0] rom [0:Q];

    for (genvar j = 0; j <= Q; j++) begin : g_rom
        assign rom[j] = (BITSIZE-1)'(lut_entry(AMP, j, F_SINE));
    end

    // ROM read; addresses beyond Q are never issued by the top level.
    always_comb begin
        data_o = '0;
        if (addr_i <= AW'(Q))
            data_o = rom[addr_i];
    end
endmodule

// File: rtl/sine_stream_source.sv
// Quantized offset-binary sine source: one sample per PERIOD clocks with a one-cycle strobe.
module sine_stream_source
    import sine_stream_pkg::*;
#(
    parameter int unsigned BITSIZE     = 12,
    parameter int unsigned F_SINE      = 256,
    parameter int unsigned NUM_PERIODS = 8,
    parameter int unsigned PERIOD      = 8,
    parameter int unsigned AMP_MARGIN  = 10
) (
    input  logic           CLK,
    input  logic           nRST,
    sine_stream_if.master  bus
);
    localparam int unsigned Q   = F_SINE / 4;
    localparam int unsigned PHW = cnt_width(F_SINE);
    localparam int unsigned IVW = cnt_width(PERIOD);
    localparam int unsigned PCW = cnt_width(NUM_PERIODS);
    localparam int unsigned LAW = cnt_width(Q + 1);
    localparam logic [BITSIZE-1:0]   MID_U = BITSIZE'(mid_of(BITSIZE));
    localparam logic signed [BITSIZE:0] MID_S = (BITSIZE+1)'(mid_of(BITSIZE));

    state_e             state_q, state_d;
    logic [IVW-1:0]     ivl_q, ivl_d;
    logic [PHW-1:0]     phase_q, phase_d;
    logic [PCW-1:0]     per_q, per_d;
    logic               last_q, last_d;
    logic [BITSIZE-1:0] data_q, data_d;
    logic               strobe_q, strobe_d;

    logic [PHW-1:0]        lut_idx;
    logic [BITSIZE-2:0]    lut_val;
    logic signed [BITSIZE:0] lut_ext;
    logic signed [BITSIZE:0] sample;

    sine_quarter_lut #(
        .BITSIZE    (BITSIZE),
        .F_SINE     (F_SINE),
        .AMP_MARGIN (AMP_MARGIN),
        .AW         (LAW)
    ) u_lut (
        .addr_i (LAW'(lut_idx)),
        .data_o (lut_val)
    );

    // Fold the phase into the first quadrant and apply the half-wave sign around MID.
    always_comb begin
        lut_idx = phase_q;
        unique case (phase_q[PHW-1 -: 2])
            2'd0:    lut_idx = phase_q;
            2'd1:    lut_idx = PHW'(2 * Q) - phase_q;
            2'd2:    lut_idx = phase_q - PHW'(2 * Q);
            default: lut_idx = PHW'(0) - phase_q;  // 4Q wraps to 0, giving F_SINE-p
        endcase
        lut_ext = $signed({2'b00, lut_val});
        sample  = phase_q[PHW-1] ? (MID_S - lut_ext) : (MID_S + lut_ext);
    end

    // State register and counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            ivl_q    <= '0;
            phase_q  <= '0;
            per_q    <= '0;
            last_q   <= 1'b0;
            data_q   <= MID_U;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ivl_q    <= ivl_d;
            phase_q  <= phase_d;
            per_q    <= per_d;
            last_q   <= last_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    // Next-state: abort has priority over both the run end and a due strobe.
    always_comb begin
        state_d  = state_q;
        ivl_d    = ivl_q;
        phase_d  = phase_q;
        per_d    = per_q;
        last_d   = last_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.EN) begin
                    state_d = RUN;
                    ivl_d   = '0;
                    phase_d = '0;
                    per_d   = '0;
                    last_d  = 1'b0;
                end
            end
            RUN: begin
                if (!bus.EN) begin
                    state_d = IDLE;
                    data_d  = MID_U;
                end else if (last_q) begin
                    state_d = DONE;
                end else if (ivl_q == IVW'(PERIOD - 1)) begin
                    ivl_d    = '0;
                    strobe_d = 1'b1;
                    data_d   = BITSIZE'(sample);
                    phase_d  = phase_q + 1'b1;
                    if (phase_q == PHW'(F_SINE - 1)) begin
                        per_d = per_q + 1'b1;
                        if ((NUM_PERIODS != 0) && (per_q == PCW'(NUM_PERIODS - 1)))
                            last_d = 1'b1;
                    end
                end else begin
                    ivl_d = ivl_q + 1'b1;
                end
            end
            DONE: begin
                if (!bus.EN) begin
                    state_d = IDLE;
                    data_d  = MID_U;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output drive.
    always_comb begin
        bus.DATA_OUT   = data_q;
        bus.START_FLAG = strobe_q;
        bus.BUSY       = (state_q == RUN);
        bus.DONE       = (state_q == DONE);
    end
endmodule

// File: tb/tb_sine_stream_source.sv
// Self-checking bench for sine_stream_source: directed runs, table checks, random enable vs model.
module tb_sine_stream_source;
    localparam int BITSIZE = 12;
    localparam int F       = 256;
    localparam int PERIOD  = 8;
    localparam int NP_A    = 2;
    localparam int MID     = 2048;
    localparam int AMP     = 2038;
    localparam real PI_R   = 3.14159265358979323846;

    logic CLK;
    logic nRST;

    sine_stream_if #(.BITSIZE(BITSIZE)) ifa ();
    sine_stream_if #(.BITSIZE(BITSIZE)) ifc ();

    sine_stream_source #(
        .BITSIZE(BITSIZE), .F_SINE(F), .NUM_PERIODS(NP_A), .PERIOD(PERIOD), .AMP_MARGIN(10)
    ) dut_a (.CLK(CLK), .nRST(nRST), .bus(ifa.master));

    sine_stream_source #(
        .BITSIZE(BITSIZE), .F_SINE(F), .NUM_PERIODS(0), .PERIOD(PERIOD), .AMP_MARGIN(10)
    ) dut_c (.CLK(CLK), .nRST(nRST), .bus(ifc.master));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int idx;
        int expv;
    } vec_t;

    vec_t vecs [6];
    int   cap  [0:511];

    // Full-wave reference: MID + round(AMP*sin(2*pi*n/F)), half away from zero.
    function automatic int ref_sample(input int n);
        real x;
        int  r;
        x = real'(AMP) * $sin(2.0 * PI_R * real'(n) / real'(F));
        r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
        return MID + r;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int nstr, last_k, done_k, mn, mx, s256, done_hits;
        int m_state, m_t, m_n, m_data, m_strobe, hold;
        logic en_r;

        vecs[0] = '{0, 2048};
        vecs[1] = '{32, 3489};
        vecs[2] = '{64, 4086};
        vecs[3] = '{128, 2048};
        vecs[4] = '{192, 10};
        vecs[5] = '{256, 2048};

        // Reset and idle
        nRST = 1'b0;
        ifa.EN = 1'b0;
        ifc.EN = 1'b0;
        #23;
        check("rst_data", int'(ifa.DATA_OUT), MID);
        check("rst_flag", int'(ifa.START_FLAG), 0);
        check("rst_busy", int'(ifa.BUSY), 0);
        check("rst_done", int'(ifa.DONE), 0);
        check("rst_data_c", int'(ifc.DATA_OUT), MID);
        @(negedge CLK);
        nRST = 1'b1;
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            check("idle_data", int'(ifa.DATA_OUT), MID);
            check("idle_flag", int'(ifa.START_FLAG), 0);
            check("idle_busy", int'(ifa.BUSY), 0);
            check("idle_done", int'(ifa.DONE), 0);
        end

        // Full run with NUM_PERIODS = 2
        ifa.EN = 1'b1;
        tick();
        check("entry_busy", int'(ifa.BUSY), 1);
        check("entry_flag", int'(ifa.START_FLAG), 0);
        nstr = 0; last_k = -1; done_k = -1;
        for (int k = 1; k <= 5000 && done_k < 0; k++) begin
            tick();
            if (ifa.START_FLAG) begin
                if (nstr == 0) check("first_strobe_delay", k, PERIOD);
                else           check("strobe_spacing", k - last_k, PERIOD);
                if (nstr < 512) cap[nstr] = int'(ifa.DATA_OUT);
                check("run_sample", int'(ifa.DATA_OUT), ref_sample(nstr % F));
                nstr++;
                last_k = k;
            end
            if (ifa.DONE) done_k = k;
        end
        check("run_done_seen", int'(done_k >= 0), 1);
        check("run_strobe_count", nstr, 512);
        check("done_after_last", done_k - last_k, 1);
        check("done_busy_low", int'(ifa.BUSY), 0);
        for (int unsigned i = 0; i < 6; i++)
            check($sformatf("table_idx%0d", vecs[i].idx), cap[vecs[i].idx], vecs[i].expv);
        mn = 1 << 30; mx = -1;
        for (int unsigned i = 0; i < 256; i++) begin
            if (cap[i] < mn) mn = cap[i];
            if (cap[i] > mx) mx = cap[i];
        end
        check("period_min", mn, 10);
        check("period_max", mx, 4086);
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check("done_hold", int'(ifa.DONE), 1);
            check("done_data_hold", int'(ifa.DATA_OUT), ref_sample(255));
            check("done_no_flag", int'(ifa.START_FLAG), 0);
        end
        ifa.EN = 1'b0;
        tick();
        check("done_exit_done", int'(ifa.DONE), 0);
        check("done_exit_busy", int'(ifa.BUSY), 0);

        // Abort on the edge a strobe is due
        ifa.EN = 1'b1;
        tick();
        for (int unsigned i = 0; i < 23; i++) tick();
        check("pre_abort_data", int'(ifa.DATA_OUT), ref_sample(1));
        ifa.EN = 1'b0;
        tick();
        check("abort_no_flag", int'(ifa.START_FLAG), 0);
        check("abort_data_mid", int'(ifa.DATA_OUT), MID);
        check("abort_busy", int'(ifa.BUSY), 0);
        ifa.EN = 1'b1;
        tick();
        for (int unsigned i = 0; i < 7; i++) tick();
        check("restart_no_early_flag", int'(ifa.START_FLAG), 0);
        tick();
        check("restart_flag0", int'(ifa.START_FLAG), 1);
        check("restart_sample0", int'(ifa.DATA_OUT), ref_sample(0));
        for (int unsigned i = 0; i < 8; i++) tick();
        check("restart_flag1", int'(ifa.START_FLAG), 1);
        check("restart_sample1", int'(ifa.DATA_OUT), ref_sample(1));

        // Asynchronous reset mid-run at phase 100
        ifa.EN = 1'b0;
        tick();
        ifa.EN = 1'b1;
        tick();
        nstr = 0;
        for (int k = 1; k <= 100 * PERIOD + 20 && nstr < 100; k++) begin
            tick();
            if (ifa.START_FLAG) nstr++;
        end
        check("pre_reset_strobes", nstr, 100);
        check("pre_reset_data", int'(ifa.DATA_OUT), ref_sample(99));
        #1;
        nRST = 1'b0;
        #1;
        check("async_rst_data", int'(ifa.DATA_OUT), MID);
        check("async_rst_busy", int'(ifa.BUSY), 0);
        check("async_rst_flag", int'(ifa.START_FLAG), 0);
        check("async_rst_done", int'(ifa.DONE), 0);
        ifa.EN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        ifa.EN = 1'b1;
        tick();
        for (int unsigned i = 0; i < 8; i++) tick();
        check("post_rst_flag", int'(ifa.START_FLAG), 1);
        check("post_rst_sample0", int'(ifa.DATA_OUT), ref_sample(0));
        for (int unsigned i = 0; i < 8; i++) tick();
        check("post_rst_sample1", int'(ifa.DATA_OUT), ref_sample(1));
        ifa.EN = 1'b0;
        tick();

        // Random enable toggling against a time/strobe-count model
        m_state = 0; m_t = 0; m_n = 0; m_data = MID;
        en_r = 1'b0; hold = 0;
        for (int unsigned c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                en_r = ~en_r;
                hold = en_r ? int'($urandom_range(1, 160)) : int'($urandom_range(1, 6));
            end
            hold--;
            ifa.EN = en_r;
            tick();
            m_strobe = 0;
            case (m_state)
                0: if (en_r) begin m_state = 1; m_t = 0; m_n = 0; end
                1: begin
                    if (!en_r) begin
                        m_state = 0; m_data = MID;
                    end else if (m_n == NP_A * F) begin
                        m_state = 2;
                    end else begin
                        m_t++;
                        if (m_t % PERIOD == 0) begin
                            m_strobe = 1;
                            m_data = ref_sample(m_n % F);
                            m_n++;
                        end
                    end
                end
                default: if (!en_r) begin m_state = 0; m_data = MID; end
            endcase
            check("rnd_data", int'(ifa.DATA_OUT), m_data);
            check("rnd_flag", int'(ifa.START_FLAG), m_strobe);
            check("rnd_busy", int'(ifa.BUSY), int'(m_state == 1));
            check("rnd_done", int'(ifa.DONE), int'(m_state == 2));
        end
        ifa.EN = 1'b0;
        tick();

        // Continuous mode, 5000 strobes
        ifc.EN = 1'b1;
        tick();
        nstr = 0; last_k = -1; done_hits = 0; s256 = -1;
        for (int k = 1; k <= 5000 * PERIOD + 20 && nstr < 5000; k++) begin
            tick();
            if (ifc.DONE) done_hits++;
            if (ifc.START_FLAG) begin
                if (nstr == 0) check("cont_first_delay", k, PERIOD);
                else           check("cont_spacing", k - last_k, PERIOD);
                check("cont_sample", int'(ifc.DATA_OUT), ref_sample(nstr % F));
                if (nstr == 256) s256 = int'(ifc.DATA_OUT);
                nstr++;
                last_k = k;
            end
        end
        check("cont_strobe_count", nstr, 5000);
        check("cont_done_never", done_hits, 0);
        check("cont_busy", int'(ifc.BUSY), 1);
        check("cont_wrap_sample256", s256, MID);
        ifc.EN = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sine_stream_source.md
# sine_stream_source

Synthesizable stimulus source that drives the sample-stream input of the FIR delay filter (and any other filter with the same `START_FLAG`/`DATA_IN` interface) directly on the FPGA. It emits a quantized offset-binary sine, one sample per `PERIOD` clocks, each sample marked by a one-cycle `START_FLAG` strobe. It replaces the behavioural `$sin` stimulus for on-chip and post-synthesis tests, and sits between the system clock domain and the filter input.

## Interface
- `BITSIZE`, 12: sample width; unsigned offset-binary, mid-scale `MID = 1 << (BITSIZE-1)`.
- `F_SINE`, 256: samples per sine period; power of two, at least 8.
- `NUM_PERIODS`, 8: sine periods per run; 0 selects continuous output.
- `PERIOD`, 8: clock cycles between successive `START_FLAG` strobes; at least 2.
- `AMP_MARGIN`, 10: headroom below full scale; amplitude `AMP = MID - AMP_MARGIN`.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `EN`  in  1  run enable; level-sensitive.
- `DATA_OUT`  out  BITSIZE  current sample; connects to the filter `DATA_IN`.
- `START_FLAG`  out  1  one-cycle strobe; connects to the filter `START_FLAG`.
- `BUSY`  out  1  high while in state RUN.
- `DONE`  out  1  high in state DONE.

## Operation
- Reset values: `DATA_OUT = MID`, `START_FLAG = 0`, `BUSY = 0`, `DONE = 0`, all counters 0, state IDLE.
- State machine:
  - IDLE → RUN when `EN = 1`. Clear the interval counter, phase index and period counter.
  - RUN → DONE after the last sample of period `NUM_PERIODS-1` has been strobed. This transition never occurs when `NUM_PERIODS = 0`.
  - RUN → IDLE when `EN = 0` (abort).
  - DONE → IDLE when `EN = 0`. `DONE` stays high until then.
- Interval counter runs 0..`PERIOD-1` in RUN. On the edge after it reaches `PERIOD-1`:
  - register `START_FLAG = 1` for exactly one cycle;
  - register `DATA_OUT = sample(phase)`;
  - advance `phase`.
- Phase wraps from `F_SINE-1` to 0. The period counter increments on each wrap.
- Sample generation uses a quarter-wave ROM of `Q+1` entries, where `Q = F_SINE/4`:
  - `LUT[j] = round(AMP*sin(2πj/F_SINE))`, rounding half away from zero.
  - Quadrant mapping for phase `p`:
    - `[0,Q)`: `MID + LUT[p]`
    - `[Q,2Q)`: `MID + LUT[2Q-p]`
    - `[2Q,3Q)`: `MID - LUT[p-2Q]`
    - `[3Q,4Q)`: `MID - LUT[4Q-p]`
  - Compute in `BITSIZE+1`-bit signed arithmetic. By construction the result lies in `[AMP_MARGIN, 2*MID-AMP_MARGIN]`, so it never saturates.
- Abort (`EN` low in RUN): next edge returns `DATA_OUT` to `MID` with `START_FLAG = 0`. A pending strobe is not issued.
- Simultaneous events: if `EN` falls on the cycle a strobe is due, the abort wins and no strobe is issued.
- Reset mid-run: all outputs return to their reset values immediately (asynchronous).
- `DATA_OUT` holds its value between strobes, and holds the last sample in DONE.

## Timing
- First `START_FLAG` is high in the cycle `PERIOD` edges after the edge that enters RUN. Its `DATA_OUT` is `sample(0) = MID`.
- Strobe spacing is exactly `PERIOD` cycles, with no jitter and no gaps at phase wrap.
- `DATA_OUT` and `START_FLAG` change on the same edge. Data is therefore valid while the strobe is high, and the filter may sample it on the strobe cycle.
- Last strobe of a run: the next edge enters DONE, `BUSY` falls and `DONE` rises together.
- A run produces exactly `NUM_PERIODS*F_SINE` strobes.
- Re-entering RUN from IDLE always restarts at `phase = 0`.

## Structure
- Package `sine_stream_pkg` holds:
  - state enum `IDLE/RUN/DONE`;
  - `MID`/`AMP` derivation functions;
  - a `clog2`-based width constant for the phase and interval counters.
- One sub-module, `sine_quarter_lut`:
  - combinational or registered ROM, `Q+1` entries of `BITSIZE-1` bits, generated from parameters at elaboration;
  - if the ROM is registered, add one pipeline stage ahead of the strobe so the output timing stated above still holds.

## Test plan
- Reset/enable: `nRST` low then high, `EN = 0` for 20 cycles → `DATA_OUT = 2048`, `START_FLAG`/`BUSY`/`DONE` stay 0. Raise `EN` → first strobe 8 cycles later with `DATA_OUT = 2048`.
- Waveform values at `BITSIZE = 12`, `F_SINE = 256`: sample index 32 → 3489, 64 → 4086, 128 → 2048, 192 → 10. Over one period, min = 10 and max = 4086. Compare every sample against a bench model.
- Run length with `NUM_PERIODS = 2`: exactly 512 strobes, each spaced 8 cycles. `DONE` rises one edge after the last strobe. Lowering `EN` → IDLE, `DONE = 0`.
- Abort: drop `EN` on the cycle a strobe is due → no strobe, `DATA_OUT = 2048` on the next edge. Re-enable → restart at `sample(0)`.
- Asynchronous reset mid-run at phase 100 → outputs reset without waiting for `CLK`. Subsequent run restarts at phase 0.
- Continuous mode with `NUM_PERIODS = 0`: 5000 strobes → `DONE` never asserts, phase wraps cleanly (sample 256 equals sample 0 = 2048).
